instr_fetch_sequencer: RTL

//  Sequences the 8-bit program memory for the Harvard CPU. Drives its address,

---
 rtl/cpu_defs_pkg.sv | 28 ++
 rtl/ifu_len_decode.sv | 33 +++
 rtl/instr_fetch_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared opcode, length and fetch FSM encodings for the Harvard CPU.
// Consumed by the fetch sequencer and its length decoder.
package cpu_defs;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_MOVRA = 8'h04;
  localparam logic [7:0] OP_MOVAR = 8'h05;
  localparam logic [7:0] OP_MOVIR = 8'h06;
  localparam logic [7:0] OP_JMP   = 8'h07;
  localparam logic [7:0] OP_JNB   = 8'h09;
  localparam logic [7:0] OP_CLR   = 8'h12;

  localparam logic [1:0] LEN_0 = 2'd0;
  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_OP1  = 3'd1,
    S_OP2  = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } ifu_state_t;

endpackage

// File: rtl/ifu_len_decode.sv
// Combinational opcode -> {instruction length, legal} table.
// Unknown opcodes report length 1 so they can still be presented.
module ifu_len_decode
  import cpu_defs::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] opcode,
  output logic [1:0]    len,
  output logic          legal
);

  always_comb begin
    len   = LEN_1;
    legal = 1'b1;
    case (opcode)
      DW'(OP_NOP):   len = LEN_1;
      DW'(OP_ADD):   len = LEN_2;
      DW'(OP_SUB):   len = LEN_2;
      DW'(OP_MOVRA): len = LEN_3;
      DW'(OP_MOVAR): len = LEN_3;
      DW'(OP_MOVIR): len = LEN_3;
      DW'(OP_JMP):   len = LEN_2;
      DW'(OP_JNB):   len = LEN_3;
      DW'(OP_CLR):   len = LEN_1;
      default: begin
        len   = LEN_1;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Program-memory fetch sequencer: PC, instruction assembly, jump redirect.
// Define IFU_ILLEGAL_TRAP_EN to halt on an illegal opcode.
module instr_fetch_sequencer
  import cpu_defs::*;
#(
  parameter int             AW       = 8,
  parameter int             DW       = 8,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [AW-1:0] pm_addr,
  input  logic [DW-1:0] pm_data,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr_opcode,
  output logic [DW-1:0] instr_op1,
  output logic [DW-1:0] instr_op2,
  output logic [1:0]    instr_len,
  output logic [AW-1:0] instr_pc,
  input  logic          jump_valid,
  input  logic [AW-1:0] jump_target,
  output logic          illegal
);

  ifu_state_t    state, state_d;
  logic [AW-1:0] pc, pc_d;
  logic [AW-1:0] ipc_d;
  logic [DW-1:0] opc_d, op1_d, op2_d;
  logic [1:0]    len_d;
  logic          ill_q, ill_d;
  logic [1:0]    dec_len;
  logic          dec_legal;

  ifu_len_decode #(.DW(DW)) u_len (
    .opcode (pm_data),
    .len    (dec_len),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_OP;
      pc           <= RESET_PC;
      instr_pc     <= '0;
      instr_opcode <= '0;
      instr_op1    <= '0;
      instr_op2    <= '0;
      instr_len    <= LEN_0;
      ill_q        <= 1'b0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      instr_pc     <= ipc_d;
      instr_opcode <= opc_d;
      instr_op1    <= op1_d;
      instr_op2    <= op2_d;
      instr_len    <= len_d;
      ill_q        <= ill_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    ipc_d   = instr_pc;
    opc_d   = instr_opcode;
    op1_d   = instr_op1;
    op2_d   = instr_op2;
    len_d   = instr_len;
    ill_d   = ill_q;
    // A halted core ignores redirects; only rst leaves S_HALT.
    if (jump_valid && state != S_HALT) begin
      pc_d    = jump_target;
      state_d = S_OP;
    end else begin
      case (state)
        S_OP: begin
          if (run) begin
            opc_d = pm_data;
            ipc_d = pc;
            op1_d = '0;
            op2_d = '0;
            len_d = dec_len;
            ill_d = !dec_legal;
            pc_d  = pc + AW'(1);
`ifdef IFU_ILLEGAL_TRAP_EN
            if (!dec_legal)
              state_d = S_HALT;
            else if (dec_len == LEN_1)
              state_d = S_HOLD;
            else
              state_d = S_OP1;
`else
            if (dec_len == LEN_1)
              state_d = S_HOLD;
            else
              state_d = S_OP1;
`endif
          end
        end
        S_OP1: begin
          op1_d   = pm_data;
          pc_d    = pc + AW'(1);
          state_d = (instr_len == LEN_2) ? S_HOLD : S_OP2;
        end
        S_OP2: begin
          op2_d   = pm_data;
          pc_d    = pc + AW'(1);
          state_d = S_HOLD;
        end
        S_HOLD: begin
          if (instr_ready)
            state_d = S_OP;
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_OP;
      endcase
    end
  end

  assign pm_addr     = pc;
  assign instr_valid = (state == S_HOLD);
  assign illegal     = ill_q &&
                       (state == S_HOLD || state == S_HALT);

endmodule
